// File: rtl/fft16_pkg.sv
// Shared sizes and types for the 16-point FFT front-end controller.
package fft16_pkg;

   localparam int N       = 16;
   localparam int DW      = 16;
   localparam int STAGES  = 4;
   localparam int CNT_W   = 4;
   localparam int FRAME_W = N * DW;
   localparam int LAT     = 4;

   typedef logic [DW-1:0] sample_t;

endpackage

// File: rtl/fft16_sample_collector.sv
// Gathers serial samples into a held 16-sample frame and owns the frame-valid bit v0.
module fft16_sample_collector
   import fft16_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [DW-1:0]      in_data,
   input  logic               advance,
   input  logic               v0_consume,
   output logic               in_ready,
   output logic [FRAME_W-1:0] frame_x,
   output logic               v0
);

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   sample_t            samp_q [N-1];
   sample_t            samp_d [N-1];
   logic [FRAME_W-1:0] frame_x_q, frame_x_d;
   logic               v0_q, v0_d;
   logic               accept;
   logic               last_slot;

   assign last_slot = (cnt_q == CNT_W'(N-1));
   // Only the closing sample can be refused: it needs frame_x to be free.
   assign in_ready  = !(last_slot && v0_q && !advance);
   assign accept    = in_valid && in_ready;
   assign frame_x   = frame_x_q;
   assign v0        = v0_q;

   always_comb begin
      cnt_d     = cnt_q;
      samp_d    = samp_q;
      frame_x_d = frame_x_q;
      v0_d      = v0_q;
      if (v0_consume) v0_d = 1'b0;
      if (accept) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (last_slot) begin
            for (int k = 0; k < N-1; k++) frame_x_d[k*DW +: DW] = samp_q[k];
            frame_x_d[(N-1)*DW +: DW] = in_data;
            v0_d = 1'b1;
         end else begin
            samp_d[cnt_q] = in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         frame_x_q <= '0;
         v0_q      <= 1'b0;
         for (int k = 0; k < N-1; k++) samp_q[k] <= '0;
      end else begin
         cnt_q     <= cnt_d;
         frame_x_q <= frame_x_d;
         v0_q      <= v0_d;
         samp_q    <= samp_d;
      end
   end

endmodule

// File: rtl/fft16_frame_ctrl.sv
// FFT front-end: frame collection, stallable stage-enable pipeline and output handshake.
module fft16_frame_ctrl
   import fft16_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [DW-1:0]      in_data,
   output logic               in_ready,
   output logic [FRAME_W-1:0] frame_x,
   output logic               en_s1,
   output logic               en_s2,
   output logic               en_s3,
   output logic               en_s4,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [7:0]         frame_cnt
);

   logic [STAGES:1] v_q, v_d;
   logic [STAGES:1] en;
   logic [7:0]      frame_cnt_q, frame_cnt_d;
   logic            v0;
   logic            advance;

   fft16_sample_collector u_collect (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .advance    (advance),
      .v0_consume (advance & v0),
      .in_ready   (in_ready),
      .frame_x    (frame_x),
      .v0         (v0)
   );

   // The whole pipeline moves together; a held stage-4 result freezes it.
   assign advance = !v_q[STAGES] || out_ready;

   always_comb begin
      v_d         = v_q;
      en          = '0;
      frame_cnt_d = frame_cnt_q;
      if (advance) begin
         en  = {v_q[STAGES-1:1], v0};
         v_d = {v_q[STAGES-1:1], v0};
      end
      if (v_q[STAGES] && out_ready) frame_cnt_d = frame_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q         <= '0;
         frame_cnt_q <= '0;
      end else begin
         v_q         <= v_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign en_s1     = en[1];
   assign en_s2     = en[2];
   assign en_s3     = en[3];
   assign en_s4     = en[4];
   assign out_valid = v_q[STAGES];
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft16_frame_ctrl.sv
// Self-checking bench for fft16_frame_ctrl against a frame-level behavioural model.
module tb_fft16_frame_ctrl;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [15:0]  in_data = '0;
   logic         out_ready = 1'b1;
   logic         in_ready;
   logic [255:0] frame_x;
   logic         en_s1, en_s2, en_s3, en_s4;
   logic         out_valid;
   logic [7:0]   frame_cnt;

   fft16_frame_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .frame_x   (frame_x),
      .en_s1     (en_s1),
      .en_s2     (en_s2),
      .en_s3     (en_s3),
      .en_s4     (en_s4),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int ovq[$];

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Model: each in-flight frame is tracked by its position (0 = frame_x, 1..4 = stage registers).
   int          m_cnt = 0;
   logic [15:0] m_buf [16] = '{default: '0};
   logic [255:0] m_fx = '0;
   int          m_pos[$];
   int          m_tmp[$];
   logic [7:0]  m_fcnt = '0;

   function automatic bit m_has(input int p);
      foreach (m_pos[i]) if (m_pos[i] == p) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_adv();
      return !m_has(4) || out_ready;
   endfunction

   function automatic bit m_rdy();
      return !(m_cnt == 15 && m_has(0) && !m_adv());
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt = 0;
         m_fx = '0;
         m_pos.delete();
         m_fcnt = '0;
         foreach (m_buf[i]) m_buf[i] = '0;
      end else begin
         bit adv, acc;
         adv = m_adv();
         acc = in_valid && m_rdy();
         if (adv) begin
            if (m_has(4)) m_fcnt++;
            m_tmp.delete();
            foreach (m_pos[i]) if (m_pos[i] < 4) m_tmp.push_back(m_pos[i] + 1);
            m_pos = m_tmp;
         end
         if (acc) begin
            m_buf[m_cnt] = in_data;
            if (m_cnt == 15) begin
               for (int k = 0; k < 16; k++) m_fx[16*k +: 16] = m_buf[k];
               m_pos.push_back(0);
            end
            m_cnt = (m_cnt + 1) % 16;
         end
      end
   end

   logic [3:0] e_en;
   always @(negedge clk) begin
      for (int k = 1; k <= 4; k++) e_en[k-1] = m_adv() && m_has(k-1);
      chk("in_ready",  256'(in_ready), 256'(m_rdy()));
      chk("en_s",      256'({en_s4, en_s3, en_s2, en_s1}), 256'(e_en));
      chk("out_valid", 256'(out_valid), 256'(m_has(4)));
      chk("frame_x",   frame_x, m_fx);
      chk("frame_cnt", 256'(frame_cnt), 256'(m_fcnt));
      if (out_valid) ovq.push_back(cyc);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_hs(input logic [15:0] d);
      int b;
      b = 0;
      in_valid = 1'b1;
      in_data  = d;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            tick();
            break;
         end
         b++;
         if (b > 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_hs: timeout waiting for in_ready, got 0 expected 1");
            tick();
            break;
         end
      end
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (8) tick();
   endtask

   initial begin
      #1000000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      int c_last;
      tick();
      tick();
      @(negedge clk);
      chk("rst_in_ready",  256'(in_ready), 256'(1));
      chk("rst_out_valid", 256'(out_valid), 256'(0));
      chk("rst_frame_x",   frame_x, 256'(0));
      chk("rst_en",        256'({en_s4, en_s3, en_s2, en_s1}), 256'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // single frame 0x0001..0x0010, stage enables walk one per cycle
      for (int i = 1; i <= 16; i++) send_hs(16'(i));
      in_valid = 1'b0;
      @(negedge clk);
      chk("f1_slot0",  256'(frame_x[15:0]), 256'(16'h0001));
      chk("f1_slot15", 256'(frame_x[255:240]), 256'(16'h0010));
      chk("f1_en_s1",  256'({en_s4, en_s3, en_s2, en_s1}), 256'(4'b0001));
      @(negedge clk);
      chk("f1_en_s2",  256'({en_s4, en_s3, en_s2, en_s1}), 256'(4'b0010));
      @(negedge clk);
      chk("f1_en_s3",  256'({en_s4, en_s3, en_s2, en_s1}), 256'(4'b0100));
      @(negedge clk);
      chk("f1_en_s4",  256'({en_s4, en_s3, en_s2, en_s1}), 256'(4'b1000));
      @(negedge clk);
      chk("f1_out_valid", 256'(out_valid), 256'(1));
      @(negedge clk);
      chk("f1_out_valid_drop", 256'(out_valid), 256'(0));
      chk("f1_frame_cnt", 256'(frame_cnt), 256'(1));
      tick();

      // two back-to-back frames: results 16 cycles apart
      ovq.delete();
      for (int i = 0; i < 32; i++) send_hs(16'($urandom));
      drain();
      chk("b2b_pulses", 256'(ovq.size()), 256'(2));
      if (ovq.size() == 2) chk("b2b_spacing", 256'(ovq[1] - ovq[0]), 256'(16));
      chk("b2b_frame_cnt", 256'(frame_cnt), 256'(3));

      // gapped input: frame closes on the 16th accepted sample, 4 cycles to result
      ovq.delete();
      c_last = 0;
      for (int i = 0; i < 32; i++) begin
         in_valid = (i % 2 == 0);
         in_data  = 16'($urandom);
         tick();
         if (i == 30) c_last = cyc;
      end
      drain();
      chk("gap_pulses", 256'(ovq.size()), 256'(1));
      if (ovq.size() == 1) chk("gap_latency", 256'(ovq[0] - c_last), 256'(4));

      // output stall with following frames streaming in
      for (int i = 0; i < 16; i++) send_hs(16'($urandom));
      out_ready = 1'b0;
      for (int i = 0; i < 31; i++) send_hs(16'($urandom));
      in_valid = 1'b1;
      in_data  = 16'hBEEF;
      repeat (20) begin
         @(negedge clk);
         chk("stall_in_ready",  256'(in_ready), 256'(0));
         chk("stall_en",        256'({en_s4, en_s3, en_s2, en_s1}), 256'(0));
         chk("stall_out_valid", 256'(out_valid), 256'(1));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send_hs(16'hBEEF);
      in_valid = 1'b0;
      @(negedge clk);
      chk("stall_load_slot15", 256'(frame_x[255:240]), 256'(16'hBEEF));
      drain();
      chk("stall_frame_cnt", 256'(frame_cnt), 256'(7));

      // random traffic checked cycle by cycle against the model
      for (int i = 0; i < 1500; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      drain();

      // reset in the middle of a frame
      for (int i = 0; i < 9; i++) send_hs(16'($urandom));
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      repeat (3) begin
         @(negedge clk);
         chk("rst_mid_en", 256'({en_s4, en_s3, en_s2, en_s1}), 256'(0));
         chk("rst_mid_ov", 256'(out_valid), 256'(0));
      end
      tick();
      for (int i = 0; i < 16; i++) send_hs(16'h8000 + 16'(i));
      in_valid = 1'b0;
      @(negedge clk);
      chk("rst_slot0",  256'(frame_x[15:0]), 256'(16'h8000));
      chk("rst_slot15", 256'(frame_x[255:240]), 256'(16'h800F));
      drain();
      chk("rst_frame_cnt", 256'(frame_cnt), 256'(1));

      // 255 more frames with random back-pressure: counter wraps to zero
      for (int f = 0; f < 255; f++) begin
         for (int i = 0; i < 16; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            send_hs(16'($urandom));
         end
      end
      drain();
      chk("wrap_frame_cnt", 256'(frame_cnt), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
